ysyx_22050078_ifid_buf: RTL



---
 rtl/ysyx_22050078_ifid_buf.sv | 99 +++++++++
 1 files changed

// File: rtl/ysyx_22050078_ifid_buf.sv
// Fetch-to-decode 2-entry skid buffer; pc/inst pushed at edge N appear on o_* in cycle N+1.
// Backpressure: o_ready comes only from registered occupancy, never from i_ready.
// Flush empties the buffer and discards a same-cycle push.
module ysyx_22050078_ifid_buf #(
  parameter int CPU_WIDTH  = 64,
  parameter int INST_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [CPU_WIDTH-1:0]  i_pc,
  input  logic [INST_WIDTH-1:0] i_inst,
  input  logic                  i_flush,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [CPU_WIDTH-1:0]  o_pc,
  output logic [INST_WIDTH-1:0] o_inst,
  output logic [1:0]            o_count
);

  typedef struct packed {
    logic [CPU_WIDTH-1:0]  pc;
    logic [INST_WIDTH-1:0] inst;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e state_q, state_d;
  entry_t head_q, head_d;
  entry_t tail_q, tail_d;
  entry_t in_ent;
  logic   push, pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Head always holds the oldest entry, so the output side never needs a mux.
  always_comb begin
    in_ent  = {i_pc, i_inst};
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (i_flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = ONE;
            head_d  = in_ent;
          end
        end
        ONE: begin
          case ({push, pop})
            2'b10: begin
              state_d = FULL;
              tail_d  = in_ent;
            end
            2'b01: state_d = EMPTY;
            2'b11: head_d = in_ent;
            default: ;
          endcase
        end
        FULL: begin
          if (pop) begin
            state_d = ONE;
            head_d  = tail_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    o_ready = !rst && (state_q != FULL);
    o_valid = (state_q != EMPTY);
    o_count = state_q;
    o_pc    = head_q.pc;
    o_inst  = head_q.inst;
    push    = i_valid && o_ready;
    pop     = o_valid && i_ready;
  end

endmodule
